// File: rtl/dreimann_round_ctrl_pkg.sv
// Shared definitions for the Drei-Mann round controller: verdict codes,
// FSM state encoding and small classification helpers.
package dreimann_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVAL     = 3'd1,
    ST_SHOW     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_e;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_SUM9      = 3'd1;
  localparam logic [2:0] CODE_SUM8      = 3'd2;
  localparam logic [2:0] CODE_SUM7      = 3'd3;
  localparam logic [2:0] CODE_DREIMANN  = 3'd4;
  localparam logic [2:0] CODE_DOUBLE    = 3'd5;
  localparam logic [2:0] CODE_TRIPLE_DM = 3'd6;
  localparam logic [2:0] CODE_INVALID   = 3'd7;

  localparam logic [3:0] DM_COUNT_MAX = 4'd15;

  function automatic logic die_legal(input logic [2:0] d);
    return (d != 3'd0) && (d != 3'd7);
  endfunction

  function automatic logic is_dm_event(input logic [2:0] code);
    return (code == CODE_DREIMANN) || (code == CODE_TRIPLE_DM);
  endfunction

endpackage

// File: rtl/dreimann_classify.sv
// Combinational Drei-Mann classifier: maps a pair of die values to a
// verdict code and their sum (sum forced to 0 for illegal dice).
module dreimann_classify
  import dreimann_round_ctrl_pkg::*;
(
  input  logic [2:0] d1_i,
  input  logic [2:0] d2_i,
  output logic [2:0] code_o,
  output logic [3:0] sum_o
);

  logic [3:0] raw_sum;

  assign raw_sum = {1'b0, d1_i} + {1'b0, d2_i};

  always_comb begin
    code_o = CODE_NONE;
    sum_o  = raw_sum;
    if (!die_legal(d1_i) || !die_legal(d2_i)) begin
      code_o = CODE_INVALID;
      sum_o  = 4'd0;
    end else if ((d1_i == 3'd3) && (d2_i == 3'd3)) begin
      code_o = CODE_TRIPLE_DM;
    end else if (d1_i == d2_i) begin
      code_o = CODE_DOUBLE;
    end else if ((d1_i == 3'd3) || (d2_i == 3'd3) || (raw_sum == 4'd3)) begin
      code_o = CODE_DREIMANN;
    end else begin
      case (raw_sum)
        4'd7:    code_o = CODE_SUM7;
        4'd8:    code_o = CODE_SUM8;
        4'd9:    code_o = CODE_SUM9;
        default: code_o = CODE_NONE;
      endcase
    end
  end

endmodule

// File: rtl/dreimann_round_ctrl.sv
// Round controller: waits for both dice frozen, shows the verdict for a
// fixed window with a blink cue, then pulses clear to release the dice.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for both rolled flags; dice captured on exit
// ST_EVAL     | one cycle; classifier output registered on exit
// ST_SHOW     | verdict on display for HOLD_CYCLES cycles, blink running
// ST_CLEAR    | one-cycle clear pulse to the dice controllers
// ST_WAIT_REL | waiting for both rolled flags to drop before a new round
module dreimann_round_ctrl
  import dreimann_round_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 10_000_000,
  parameter int unsigned BLINK_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] dice1,
  input  logic [2:0] dice2,
  input  logic       rolled1,
  input  logic       rolled2,
  input  logic       cnt_clr,
  output logic       clear,
  output logic       result_valid,
  output logic [2:0] result_code,
  output logic [3:0] sum,
  output logic [3:0] dm_count,
  output logic       blink,
  output logic       busy
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

  state_e state_q, state_d;

  logic [2:0]         dice1_q, dice1_d;
  logic [2:0]         dice2_q, dice2_d;
  logic [2:0]         code_q, code_d;
  logic [3:0]         sum_q, sum_d;
  logic [3:0]         dm_count_q, dm_count_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               valid_q, valid_d;
  logic               clear_q, clear_d;
  logic               busy_q, busy_d;

  logic [2:0] cls_code;
  logic [3:0] cls_sum;

  dreimann_classify u_classify (
    .d1_i   (dice1_q),
    .d2_i   (dice2_q),
    .code_o (cls_code),
    .sum_o  (cls_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rolled1 && rolled2) state_d = ST_EVAL;
      ST_EVAL:     state_d = ST_SHOW;
      ST_SHOW:     if (hold_cnt_q == '0) state_d = ST_CLEAR;
      ST_CLEAR:    state_d = ST_WAIT_REL;
      ST_WAIT_REL: if (!rolled1 && !rolled2) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dice1_d     = dice1_q;
    dice2_d     = dice2_q;
    code_d      = code_q;
    sum_d       = sum_q;
    dm_count_d  = dm_count_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = 1'b0;

    if ((state_q == ST_IDLE) && (state_d == ST_EVAL)) begin
      dice1_d = dice1;
      dice2_d = dice2;
    end

    if (state_q == ST_EVAL) begin
      code_d     = cls_code;
      sum_d      = cls_sum;
      hold_cnt_d = HOLD_LOAD;
    end else if ((state_q == ST_SHOW) && (hold_cnt_q != '0)) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end

    // Blink restarts high on every SHOW entry; a NONE verdict keeps it steady.
    if (state_d == ST_SHOW) begin
      if (state_q != ST_SHOW) begin
        blink_d     = 1'b1;
        blink_cnt_d = BLINK_LOAD;
      end else if (code_q == CODE_NONE) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == '0) begin
        blink_d     = ~blink_q;
        blink_cnt_d = BLINK_LOAD;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q - BLINK_W'(1);
      end
    end

    if (cnt_clr) begin
      dm_count_d = 4'd0;
    end else if ((state_q == ST_EVAL) && is_dm_event(cls_code) &&
                 (dm_count_q != DM_COUNT_MAX)) begin
      dm_count_d = dm_count_q + 4'd1;
    end

    valid_d = (state_d == ST_SHOW);
    clear_d = (state_d == ST_CLEAR);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dice1_q     <= 3'd0;
      dice2_q     <= 3'd0;
      code_q      <= CODE_NONE;
      sum_q       <= 4'd0;
      dm_count_q  <= 4'd0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      valid_q     <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      dice1_q     <= dice1_d;
      dice2_q     <= dice2_d;
      code_q      <= code_d;
      sum_q       <= sum_d;
      dm_count_q  <= dm_count_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      valid_q     <= valid_d;
      clear_q     <= clear_d;
      busy_q      <= busy_d;
    end
  end

  assign clear        = clear_q;
  assign result_valid = valid_q;
  assign result_code  = code_q;
  assign sum          = sum_q;
  assign dm_count     = dm_count_q;
  assign blink        = blink_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dreimann_round_ctrl.sv
// Self-checking bench for dreimann_round_ctrl with a small behavioural
// model of the round rules and randomized dice/flag noise.
module tb_dreimann_round_ctrl;

  localparam int HOLD  = 8;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dice1, dice2;
  logic       rolled1, rolled2, cnt_clr;
  logic       clear, result_valid, blink, busy;
  logic [2:0] result_code;
  logic [3:0] sum, dm_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  dreimann_round_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dice1        (dice1),
    .dice2        (dice2),
    .rolled1      (rolled1),
    .rolled2      (rolled2),
    .cnt_clr      (cnt_clr),
    .clear        (clear),
    .result_valid (result_valid),
    .result_code  (result_code),
    .sum          (sum),
    .dm_count     (dm_count),
    .blink        (blink),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_classify(input int a, input int b, output int code, output int s);
    if (a < 1 || a > 6 || b < 1 || b > 6) begin
      code = 7;
      s    = 0;
    end else begin
      s = a + b;
      if (a == 3 && b == 3)                code = 6;
      else if (a == b)                     code = 5;
      else if (a == 3 || b == 3 || s == 3) code = 4;
      else if (s == 7)                     code = 3;
      else if (s == 8)                     code = 2;
      else if (s == 9)                     code = 1;
      else                                 code = 0;
    end
  endfunction

  task automatic do_round(input logic [2:0] d1, input logic [2:0] d2,
                          input int rel_wait, input logic clr_in_eval);
    int   ecode, esum, nwait;
    logic exp_blink;
    ref_classify(int'(d1), int'(d2), ecode, esum);

    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL round_start_idle: busy=%0b expected 0", busy);
    end
    dice1 = d1; dice2 = d2; rolled1 = 1'b1; rolled2 = 1'b1;

    @(negedge clk);
    checks++;
    if ({busy, result_valid, clear} !== 3'b100) begin
      failures++;
      $display("FAIL eval_flags: {busy,valid,clear}=%b expected 100", {busy, result_valid, clear});
    end
    cnt_clr = clr_in_eval;
    dice1 = 3'($urandom_range(0, 7));
    dice2 = 3'($urandom_range(0, 7));
    if (clr_in_eval) exp_cnt = 0;
    else if ((ecode == 4 || ecode == 6) && exp_cnt < 15) exp_cnt++;

    for (int k = 0; k < HOLD; k++) begin
      @(negedge clk);
      exp_blink = (ecode == 0) ? 1'b1 : (((k / BLINK) % 2) == 0);
      checks++;
      if ({result_valid, clear, busy, blink} !== {3'b101, exp_blink}) begin
        failures++;
        $display("FAIL show_flags k=%0d: {valid,clear,busy,blink}=%b expected %b",
                 k, {result_valid, clear, busy, blink}, {3'b101, exp_blink});
      end
      checks++;
      if (result_code !== 3'(ecode) || sum !== 4'(esum)) begin
        failures++;
        $display("FAIL show_verdict dice=%0d,%0d: code=%0d sum=%0d expected code=%0d sum=%0d",
                 d1, d2, result_code, sum, ecode, esum);
      end
      checks++;
      if (dm_count !== 4'(exp_cnt)) begin
        failures++;
        $display("FAIL show_dm_count: dm_count=%0d expected %0d", dm_count, exp_cnt);
      end
      cnt_clr = 1'b0;
      dice1   = 3'($urandom_range(0, 7));
      dice2   = 3'($urandom_range(0, 7));
      rolled1 = 1'($urandom_range(0, 1));
      rolled2 = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    checks++;
    if ({clear, result_valid, busy, blink} !== 4'b1010) begin
      failures++;
      $display("FAIL clear_pulse: {clear,valid,busy,blink}=%b expected 1010",
               {clear, result_valid, busy, blink});
    end
    rolled1 = (rel_wait > 0);
    rolled2 = (rel_wait > 0);
    nwait   = (rel_wait > 0) ? rel_wait : 1;

    for (int r = 0; r < nwait; r++) begin
      @(negedge clk);
      checks++;
      if ({clear, result_valid, busy, blink} !== 4'b0010) begin
        failures++;
        $display("FAIL wait_rel r=%0d: {clear,valid,busy,blink}=%b expected 0010",
                 r, {clear, result_valid, busy, blink});
      end
      if (rel_wait > 0 && r == rel_wait - 1) begin
        rolled1 = 1'b0;
        rolled2 = 1'b0;
      end
    end

    @(negedge clk);
    checks++;
    if ({clear, result_valid, busy, blink} !== 4'b0000) begin
      failures++;
      $display("FAIL back_idle: {clear,valid,busy,blink}=%b expected 0000",
               {clear, result_valid, busy, blink});
    end
    checks++;
    if (result_code !== 3'(ecode) || sum !== 4'(esum) || dm_count !== 4'(exp_cnt)) begin
      failures++;
      $display("FAIL held_after_round: code=%0d sum=%0d cnt=%0d expected %0d %0d %0d",
               result_code, sum, dm_count, ecode, esum, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rolled1 = 1'b0; rolled2 = 1'b0; cnt_clr = 1'b0;
    dice1 = 3'd0; dice2 = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({clear, result_valid, blink, busy, result_code, sum, dm_count} !== 15'd0) begin
      failures++;
      $display("FAIL reset_values: clear=%0b valid=%0b blink=%0b busy=%0b code=%0d sum=%0d cnt=%0d expected all 0",
               clear, result_valid, blink, busy, result_code, sum, dm_count);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_dreimann();
    do_round(3'd1, 3'd2, 0, 1'b0);
  endtask

  task automatic test_triple_double();
    do_round(3'd3, 3'd3, 0, 1'b0);
    do_round(3'd4, 3'd4, 0, 1'b0);
  endtask

  task automatic test_sums();
    do_round(3'd2, 3'd5, 0, 1'b0);
    do_round(3'd1, 3'd4, 0, 1'b0);
    do_round(3'd6, 3'd2, 1, 1'b0);
    do_round(3'd4, 3'd5, 0, 1'b0);
  endtask

  task automatic test_single_flag();
    rolled1 = 1'b1; rolled2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL single_flag1 i=%0d: busy=%0b expected 0", i, busy);
      end
    end
    rolled1 = 1'b0; rolled2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL single_flag2 i=%0d: busy=%0b expected 0", i, busy);
      end
    end
    rolled2 = 1'b0;
  endtask

  task automatic test_wait_rel();
    do_round(3'd5, 3'd2, 6, 1'b0);
  endtask

  task automatic test_invalid();
    do_round(3'd0, 3'd4, 0, 1'b0);
    do_round(3'd7, 3'd3, 0, 1'b0);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_cnt = 0;
    checks++;
    if (dm_count !== 4'd0) begin
      failures++;
      $display("FAIL idle_cnt_clr: dm_count=%0d expected 0", dm_count);
    end
    for (int i = 0; i < 16; i++) begin
      case (i % 3)
        0:       do_round(3'd1, 3'd2, 0, 1'b0);
        1:       do_round(3'd3, 3'd5, 0, 1'b0);
        default: do_round(3'd6, 3'd3, 0, 1'b0);
      endcase
    end
    checks++;
    if (dm_count !== 4'd15) begin
      failures++;
      $display("FAIL saturation: dm_count=%0d expected 15", dm_count);
    end
  endtask

  task automatic test_cnt_clr();
    do_round(3'd3, 3'd3, 0, 1'b1);
    do_round(3'd2, 3'd1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      do_round(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_reset_mid_round();
    @(negedge clk);
    dice1 = 3'd1; dice2 = 3'd2; rolled1 = 1'b1; rolled2 = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort_show: valid=%0b expected 1", result_valid);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({clear, result_valid, blink, busy, result_code, sum, dm_count} !== 15'd0) begin
      failures++;
      $display("FAIL abort_reset_values: clear=%0b valid=%0b blink=%0b busy=%0b code=%0d sum=%0d cnt=%0d expected all 0",
               clear, result_valid, blink, busy, result_code, sum, dm_count);
    end
    rolled1 = 1'b0; rolled2 = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({clear, busy, result_valid} !== 3'b000) begin
        failures++;
        $display("FAIL after_abort i=%0d: {clear,busy,valid}=%b expected 000",
                 i, {clear, busy, result_valid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_dreimann();
    test_triple_double();
    test_sums();
    test_single_flag();
    test_wait_rel();
    test_invalid();
    test_saturation();
    test_cnt_clr();
    test_random();
    test_reset_mid_round();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
